// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
//   Iterative multiply/divide sequencer owning the HI/LO write port.
//   MULT/MULTU use one-bit-per-cycle shift/add on operand magnitudes;
//   DIV/DIVU use restoring division. Sign correction is applied in FIX,
//   and results are written back with a single-cycle strobe in WB.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, op           issue request from ID; op = MULT/MULTU/DIV/DIVU
//   src_a, src_b        rs / rt operands, sampled only in the accept cycle
//   hilo_rd             ID is decoding MFHI/MFLO
//   flush               abandon any operation in progress
//   busy, stall         sequencer occupied; ID hold request
//   hi_out, lo_out      registered results, updated only in FIX
//   hi_we, lo_we, done  one-cycle write strobes / completion pulse
//   div_zero            pulses with done for a divide by zero
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_we,
  output logic             lo_we,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, WB} state_t;

  state_t             state, state_nxt;
  logic               div_r;     // operation in flight is a divide
  logic               sa, sb;    // operand sign flags (0 for unsigned ops)
  logic               dz_r;      // divide by zero detected at accept
  logic [WIDTH-1:0]   a_r;       // multiplicand / dividend (shifts left)
  logic [WIDTH-1:0]   b_r;       // multiplier (shifts right) / divisor
  logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient}
  logic [CW-1:0]      cnt;

  logic               in_signed, in_sa, in_sb, in_bzero, accept, last;
  logic [WIDTH-1:0]   in_amag, in_bmag;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Accept-cycle operand conditioning
  always_comb begin
    in_signed = ~op[0];
    in_sa     = in_signed & src_a[WIDTH-1];
    in_sb     = in_signed & src_b[WIDTH-1];
    in_amag   = in_sa ? -src_a : src_a;
    in_bmag   = in_sb ? -src_b : src_b;
    in_bzero  = (src_b == '0);
    accept    = (state == IDLE) & start & ~flush;
    last      = (cnt == CW'(WIDTH - 1));
  end

  // Iteration and sign-correction datapath
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_r[0] ? {1'b0, a_r} : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], a_r[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, b_r});
    div_diff  = div_trial - {1'b0, b_r};
    prod_fix  = (sa ^ sb) ? -acc : acc;
    quo_fix   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (op[1] && in_bzero) ? FIX : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = flush ? IDLE : WB;
      end
      WB: begin
        busy      = 1'b1;
        state_nxt = IDLE;
        // A flush in the writeback cycle cancels the strobes outright
        if (!flush) begin
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          done     = 1'b1;
          div_zero = dz_r;
        end
      end
      default: state_nxt = IDLE;
    endcase
    stall = (start | hilo_rd) & busy;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r  <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz_r   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            div_r <= op[1];
            sa    <= in_sa;
            sb    <= in_sb;
            dz_r  <= op[1] & in_bzero;
            // Divide by zero keeps the raw dividend so FIX can return it as HI
            a_r   <= (op[1] && in_bzero) ? src_a : in_amag;
            b_r   <= in_bmag;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            if (div_r) begin
              a_r <= {a_r[WIDTH-2:0], 1'b0};
              acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
              b_r <= {1'b0, b_r[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!flush) begin
            if (dz_r) begin
              hi_out <= a_r;
              lo_out <= '1;
            end else if (div_r) begin
              hi_out <= rem_fix;
              lo_out <= quo_fix;
            end else begin
              hi_out <= prod_fix[2*WIDTH-1:WIDTH];
              lo_out <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, hilo_rd, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall, hi_we, lo_we, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int vectors = 0;
  int errors  = 0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .hilo_rd(hilo_rd), .flush(flush),
    .busy(busy), .stall(stall), .hi_out(hi_out), .lo_out(lo_out),
    .hi_we(hi_we), .lo_we(lo_we), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO semantics computed with 64-bit arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a, b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic dz);
    longint          sp, sq, sr;
    longint unsigned up;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (o)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        hi = sp[63:32]; lo = sp[31:0];
      end
      2'd1: begin
        up = longint'({32'b0, a}) * longint'({32'b0, b});
        hi = up[63:32]; lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (o == 2'd2) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          hi = sr[31:0]; lo = sq[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start; operands are scrambled afterwards
  task automatic issue(input logic [1:0] o, input logic [31:0] a, b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = $urandom; src_b = $urandom; op = 2'($urandom);
  endtask

  // Cycles (from accept) until done, 0 if never seen within bound
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin n = i; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; hilo_rd = 1'b1; flush = 1'b0;
    op = 2'd1; src_a = 32'h1234; src_b = 32'h5678;
    repeat (3) tick();
    @(negedge clk);
    vectors++;
    if ({busy, stall, done, hi_we, lo_we, div_zero} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
                         {busy, stall, done, hi_we, lo_we, div_zero});
    end
    vectors++;
    if ({hi_out, lo_out} !== 64'd0) begin
      errors++; $display("FAIL reset_hilo got %h_%h want 0_0", hi_out, lo_out);
    end
    start = 1'b0; hilo_rd = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multu_max();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int n = 1; n <= 35; n++) begin
      @(negedge clk);
      if (n == 33 || n == 35) begin
        vectors++;
        if ({done, hi_we, lo_we} !== 3'b000) begin
          errors++; $display("FAIL multu_strobe_c%0d got %b want 000", n, {done, hi_we, lo_we});
        end
      end
      if (n == 34) begin
        vectors++;
        if ({done, hi_we, lo_we, div_zero} !== 4'b1110) begin
          errors++; $display("FAIL multu_wb got %b want 1110", {done, hi_we, lo_we, div_zero});
        end
        vectors++;
        if ({hi_out, lo_out} !== 64'hFFFF_FFFE_0000_0001) begin
          errors++; $display("FAIL multu_val got %h_%h want fffffffe_00000001", hi_out, lo_out);
        end
      end
      if (n == 35) begin
        vectors++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL multu_idle busy got %b want 0", busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_signed();
    logic [1:0]  ops [3] = '{2'd0, 2'd2, 2'd2};
    logic [31:0] as  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd5, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] exp [3] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFD,
                             64'h0000_0000_8000_0000};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(n);
      vectors++;
      if (n != 34) begin
        errors++; $display("FAIL signed%0d_latency got %0d want 34", i, n);
      end
      vectors++;
      if ({hi_out, lo_out} !== exp[i]) begin
        errors++; $display("FAIL signed%0d_val got %h_%h want %h", i, hi_out, lo_out, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    issue(2'd3, 32'd100, 32'd0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 2) begin
        vectors++;
        if ({done, div_zero, hi_we, lo_we} !== 4'b1111) begin
          errors++; $display("FAIL dz_strobes got %b want 1111", {done, div_zero, hi_we, lo_we});
        end
        vectors++;
        if ({hi_out, lo_out} !== 64'h0000_0064_FFFF_FFFF) begin
          errors++; $display("FAIL dz_val got %h_%h want 00000064_ffffffff", hi_out, lo_out);
        end
      end
      if (n == 3) begin
        vectors++;
        if ({busy, done} !== 2'b00) begin
          errors++; $display("FAIL dz_idle got %b want 00", {busy, done});
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] a1 = $urandom, b1 = $urandom, a2 = $urandom, b2 = $urandom;
    logic [31:0] eh1, el1, eh2, el2;
    logic        dz;
    model(2'd1, a1, b1, eh1, el1, dz);
    model(2'd0, a2, b2, eh2, el2, dz);
    start = 1'b1; op = 2'd1; src_a = a1; src_b = b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_idle got %b want 0", stall);
    end
    tick();
    for (int n = 1; n <= 70; n++) begin
      hilo_rd = (n == 5);
      start   = (n >= 10 && n <= 35);
      op      = start ? 2'd0 : 2'd1;
      src_a   = start ? a2 : $urandom;
      src_b   = start ? b2 : $urandom;
      @(negedge clk);
      if (n == 5 || n == 10 || n == 34) begin
        vectors++;
        if (stall !== 1'b1) begin
          errors++; $display("FAIL stall_c%0d got %b want 1", n, stall);
        end
      end
      if (n == 35) begin
        vectors++;
        if ({stall, busy} !== 2'b00) begin
          errors++; $display("FAIL stall_release got %b want 00", {stall, busy});
        end
      end
      if (n == 34 || n == 69) begin
        vectors++;
        if (done !== 1'b1 || {hi_out, lo_out} !== (n == 34 ? {eh1, el1} : {eh2, el2})) begin
          errors++; $display("FAIL stall_res_c%0d got %b %h_%h want 1 %h", n, done, hi_out,
                             lo_out, (n == 34 ? {eh1, el1} : {eh2, el2}));
        end
      end
      if (n == 36 || n == 68 || n == 70) begin
        vectors++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL stall_nodone_c%0d got %b want 0", n, done);
        end
      end
      tick();
    end
    hilo_rd = 1'b0; start = 1'b0;
  endtask

  task automatic test_flush();
    logic [63:0] prev = {hi_out, lo_out};
    logic [31:0] a2 = $urandom, b2 = $urandom | 32'd1, eh, el;
    logic        dz, seen_we = 1'b0;
    model(2'd3, a2, b2, eh, el, dz);
    issue(2'd0, $urandom, $urandom);
    for (int n = 1; n <= 45; n++) begin
      flush = (n == 10);
      start = (n == 11);
      op = 2'd3; src_a = a2; src_b = b2;
      @(negedge clk);
      if (n <= 44) seen_we = seen_we | hi_we | lo_we | done;
      if (n == 11 || n == 12) begin
        vectors++;
        if (busy !== (n == 12)) begin
          errors++; $display("FAIL flush_busy_c%0d got %b want %b", n, busy, n == 12);
        end
      end
      if (n == 44) begin
        vectors++;
        if ({hi_out, lo_out} !== prev || seen_we !== 1'b0) begin
          errors++; $display("FAIL flush_hold got %h_%h we%b want %h we0", hi_out, lo_out,
                             seen_we, prev);
        end
      end
      if (n == 45) begin
        vectors++;
        if (done !== 1'b1 || {hi_out, lo_out} !== {eh, el}) begin
          errors++; $display("FAIL flush_restart got %b %h_%h want 1 %h_%h", done, hi_out,
                             lo_out, eh, el);
        end
      end
      tick();
    end
    flush = 1'b0; start = 1'b0;
    // start together with flush in IDLE is ignored
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle busy got %b want 0", busy);
    end
    tick();
    // flush during writeback suppresses the strobes
    issue(2'd1, 32'd3, 32'd4);
    for (int n = 1; n <= 35; n++) begin
      flush = (n == 34);
      @(negedge clk);
      if (n == 34) begin
        vectors++;
        if ({done, hi_we, lo_we} !== 3'b000) begin
          errors++; $display("FAIL flush_wb got %b want 000", {done, hi_we, lo_we});
        end
      end
      if (n == 35) begin
        vectors++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL flush_wb_idle got %b want 0", busy);
        end
      end
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = $urandom, b = $urandom, eh, el;
    logic        dz;
    int          n;
    issue(2'd0, $urandom, $urandom);
    for (int k = 1; k < 20; k++) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    vectors++;
    if ({busy, stall, done, hi_we, lo_we, div_zero, hi_out, lo_out} !== 70'd0) begin
      errors++; $display("FAIL midreset got %b %h_%h want all 0",
                         {busy, stall, done, hi_we, lo_we, div_zero}, hi_out, lo_out);
    end
    rst_n = 1'b1;
    tick();
    model(2'd2, a, b, eh, el, dz);
    issue(2'd2, a, b);
    wait_done(n);
    vectors++;
    if (n != (dz ? 2 : 34) || {hi_out, lo_out} !== {eh, el}) begin
      errors++; $display("FAIL postreset got n%0d %h_%h want n%0d %h_%h", n, hi_out, lo_out,
                         dz ? 2 : 34, eh, el);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, b, eh, el;
    logic [1:0]  o;
    logic        dz;
    int          n;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(o, a, b, eh, el, dz);
      issue(o, a, b);
      wait_done(n);
      vectors++;
      if (n != (dz ? 2 : 34)) begin
        errors++; $display("FAIL rand%0d_latency op%0d got %0d want %0d", i, o, n, dz ? 2 : 34);
      end
      vectors++;
      if ({hi_out, lo_out, div_zero, hi_we, lo_we} !== {eh, el, dz, 2'b11}) begin
        errors++; $display("FAIL rand%0d op%0d a=%h b=%h got %h_%h dz%b want %h_%h dz%b",
                           i, o, a, b, hi_out, lo_out, div_zero, eh, el, dz);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
